des_block_feeder: RTL and testbench

Upstream stage of DES_Cryp. Accepts a byte stream over a valid/ready handshake and packs it MSB-first into 64-bit blocks. For each block it issues a single-cycle des_cipher_en start with stable des_data and des_key_in, then stalls input until desc_ready returns. It also owns the key register, zero-pads a trailing partial block on in_last, and flags a hung engine with a timeout.

---
 rtl/des_block_feeder_if.sv | 22 ++
 rtl/des_block_feeder.sv | 125 ++++++++++++
 tb/tb_des_block_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_block_feeder_if.sv
// Byte-stream handshake into the DES block feeder.
// master drives bytes; slave (the feeder) drives in_ready.
interface des_block_feeder_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_byte,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/des_block_feeder.sv
// Packs a byte stream MSB-first into 64-bit DES blocks,
// launches DES_Cryp per block, owns the key and a hang timeout.
module des_block_feeder #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  des_block_feeder_if.slave   s,
  input  logic [63:0]         key_in,
  input  logic                key_load,
  output logic                des_cipher_en,
  output logic [63:0]         des_data,
  output logic [63:0]         des_key_in,
  input  logic                desc_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    blk_count,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [55:0] shift_q;
  logic [2:0]  cnt_q;
  logic [15:0] timer_q;
  logic [63:0] pend_key;
  logic        pend_vld;

  logic        accept;
  logic [63:0] shift_in;
  logic        blk_done;
  logic [5:0]  pad_sh;
  logic        wait_ok;
  logic        wait_to;

  assign accept   = s.in_valid & s.in_ready;
  assign shift_in = {shift_q, s.in_byte};
  assign blk_done = accept & ((cnt_q == 3'd7) | s.in_last);
  // left-align a short block: drop (7-cnt) stale bytes
  assign pad_sh   = {3'd7 - cnt_q, 3'b000};
  assign wait_ok  = (state == WAIT) & (timer_q != 16'd0)
                  & desc_ready;
  assign wait_to  = (state == WAIT)
                  & (timer_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (blk_done) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (wait_ok | wait_to) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      shift_q       <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      pend_key      <= '0;
      pend_vld      <= 1'b0;
      s.in_ready    <= 1'b0;
      des_cipher_en <= 1'b0;
      des_data      <= '0;
      des_key_in    <= '0;
      busy          <= 1'b0;
      blk_count     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      s.in_ready    <= (state_nx == FILL);
      des_cipher_en <= (state_nx == LAUNCH);
      busy          <= (state_nx != FILL);
      unique case (state)
        FILL: begin
          timer_q <= '0;
          if (key_load) des_key_in <= key_in;
          if (accept) begin
            shift_q <= shift_in[55:0];
            cnt_q   <= blk_done ? 3'd0 : cnt_q + 3'd1;
          end
          if (blk_done) des_data <= shift_in << pad_sh;
        end
        LAUNCH: begin
          timer_q <= '0;
          if (key_load) begin
            pend_key <= key_in;
            pend_vld <= 1'b1;
          end
        end
        WAIT: begin
          timer_q <= timer_q + 16'd1;
          if (wait_ok)
            blk_count <= blk_count + CNT_W'(1);
          else if (wait_to)
            timeout_err <= 1'b1;
          if (key_load) begin
            pend_key <= key_in;
            pend_vld <= 1'b1;
          end
          // deferred key lands exactly as FILL resumes
          if (state_nx == FILL) begin
            if (key_load)
              des_key_in <= key_in;
            else if (pend_vld)
              des_key_in <= pend_key;
            pend_vld <= 1'b0;
          end
        end
        default: begin
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_feeder.sv
// Directed bench for des_block_feeder with a per-cycle
// behavioural model and literal block/key/count checks.
module tb_des_block_feeder;
  localparam int TMO = 8;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   key_in = '0;
  logic          key_load = 1'b0;
  logic          desc_ready = 1'b0;
  logic          des_cipher_en;
  logic [63:0]   des_data;
  logic [63:0]   des_key_in;
  logic          busy;
  logic [CW-1:0] blk_count;
  logic          timeout_err;

  des_block_feeder_if s_if();

  des_block_feeder #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s_if),
    .key_in(key_in),
    .key_load(key_load),
    .des_cipher_en(des_cipher_en),
    .des_data(des_data),
    .des_key_in(des_key_in),
    .desc_ready(desc_ready),
    .busy(busy),
    .blk_count(blk_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] resp_mask = 32'h4;
  bit          run_cmp = 0;
  logic        rdy_q = 1'b0;
  int          en_cnt = 0;
  int          viol = 0;
  logic [63:0] cap_q[$];

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // model: transaction view of the feeder
  logic [7:0]  mq[$];
  int          mph = 0;
  int          mwc = 0;
  int          mcnt = 0;
  logic [63:0] mkey = '0;
  logic [63:0] mpk = '0;
  logic [63:0] mdata = '0;
  logic        mpv = 0;
  logic        mrdy = 0;
  logic        men = 0;
  logic        mbusy = 0;
  logic        merr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mph = 0; mwc = 0; mcnt = 0;
      mkey = '0; mpk = '0; mdata = '0; mpv = 0;
      mrdy = 0; men = 0; mbusy = 0; merr = 0;
    end else begin
      if (mph == 0) begin
        if (key_load) mkey = key_in;
        if (mrdy && s_if.in_valid) begin
          mq.push_back(s_if.in_byte);
          if (mq.size() == 8 || s_if.in_last) begin
            mdata = '0;
            foreach (mq[i])
              mdata |= 64'(mq[i]) << (56 - 8 * i);
            mq.delete();
            mph = 1;
          end
        end
      end else if (mph == 1) begin
        if (key_load) begin mpk = key_in; mpv = 1; end
        mph = 2;
        mwc = 0;
      end else begin
        mwc++;
        if (key_load) begin mpk = key_in; mpv = 1; end
        if (mwc >= 2 && desc_ready) begin
          mcnt++;
          mph = 0;
        end else if (mwc == TMO) begin
          merr = 1;
          mph = 0;
        end
        if (mph == 0) begin
          if (mpv) mkey = mpk;
          mpv = 0;
        end
      end
      mrdy  = (mph == 0);
      men   = (mph == 1);
      mbusy = (mph != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rdy_q = s_if.in_ready;
      if (des_cipher_en) begin
        cap_q.push_back(des_data);
        en_cnt++;
      end
      if (busy && s_if.in_ready) viol++;
      if (run_cmp) begin
        chk("m_in_ready", s_if.in_ready, mrdy);
        chk("m_en", des_cipher_en, men);
        chk("m_busy", busy, mbusy);
        chk("m_data", des_data, mdata);
        chk("m_key", des_key_in, mkey);
        chk("m_cnt", blk_count, 64'(mcnt % (1 << CW)));
        chk("m_err", timeout_err, merr);
      end
    end
  end

  // DES_Cryp stub: ready in WAIT cycles set in resp_mask
  initial begin
    int wc;
    wc = 99;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wc = 99;
        desc_ready = 1'b0;
      end else begin
        if (des_cipher_en) wc = 0;
        else if (wc < 99) wc++;
        desc_ready = (wc >= 1 && wc < 32) ?
                     resp_mask[wc] : 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    bit ok;
    ok = 0;
    s_if.in_byte  = b;
    s_if.in_last  = last;
    s_if.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (rdy_q) begin ok = 1; break; end
    end
    #1;
    if (!ok) bound_fail("send");
  endtask

  task automatic burst(input logic [7:0] st,
                       input logic [7:0] step,
                       input int n, input logic last);
    for (int i = 0; i < n; i++)
      send(st + step * 8'(i), last && (i == n - 1));
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
  endtask

  task automatic expect_blk(input string nm,
                            input logic [63:0] e);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      if (cap_q.size() > 0) begin ok = 1; break; end
      @(negedge clk);
      #1;
    end
    if (ok) chk(nm, cap_q.pop_front(), e);
    else bound_fail(nm);
  endtask

  task automatic wait_idle(output int n);
    bit ok;
    ok = 0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (!busy) begin ok = 1; break; end
      n++;
      @(negedge clk);
      #1;
    end
    if (!ok) bound_fail("wait_idle");
  endtask

  task automatic key_pulse(input logic [63:0] v);
    @(posedge clk);
    #1;
    key_in   = v;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, s_if.in_ready, 0);
    chk({nm, "_en"}, des_cipher_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_data"}, des_data, 0);
    chk({nm, "_key"}, des_key_in, 0);
    chk({nm, "_cnt"}, blk_count, 0);
    chk({nm, "_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int e0;
    s_if.in_byte  = '0;
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1;
    chk_zero("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", s_if.in_ready, 1);

    key_pulse(64'h1334_5779_9BBC_DFF1);
    burst(8'h01, 8'h22, 8, 0);
    expect_blk("full_blk", 64'h0123_4567_89AB_CDEF);
    chk("full_key", des_key_in, 64'h1334_5779_9BBC_DFF1);
    wait_idle(n);
    chk("full_wait", n, 3);
    chk("full_cnt", blk_count, 1);

    burst(8'hAA, 8'h11, 3, 1);
    expect_blk("pad3", 64'hAABB_CC00_0000_0000);
    wait_idle(n);
    burst(8'h11, 8'h11, 2, 1);
    expect_blk("pad2", 64'h1122_0000_0000_0000);
    wait_idle(n);
    chk("pad_cnt", blk_count, 3);

    resp_mask = 32'h22;
    viol = 0;
    burst(8'h00, 8'h01, 16, 0);
    expect_blk("stall_b1", 64'h0001_0203_0405_0607);
    expect_blk("stall_b2", 64'h0809_0A0B_0C0D_0E0F);
    wait_idle(n);
    chk("stall_wait", n, 6);
    chk("stall_cnt", blk_count, 5);
    chk("ready_in_busy", viol, 0);

    resp_mask = 32'h40;
    burst(8'h20, 8'h01, 8, 0);
    expect_blk("defer_blk", 64'h2021_2223_2425_2627);
    key_pulse({64{1'b1}});
    chk("defer_hold", des_key_in, 64'h1334_5779_9BBC_DFF1);
    wait_idle(n);
    chk("defer_apply", des_key_in, {64{1'b1}});
    burst(8'h30, 8'h01, 8, 0);
    expect_blk("defer2_blk", 64'h3031_3233_3435_3637);
    key_pulse(64'hAAAA_AAAA_AAAA_AAAA);
    key_pulse(64'h5555_5555_5555_5555);
    chk("defer2_hold", des_key_in, {64{1'b1}});
    wait_idle(n);
    chk("defer2_last", des_key_in, 64'h5555_5555_5555_5555);
    chk("defer_cnt", blk_count, 7);

    resp_mask = 32'h0;
    burst(8'h40, 8'h01, 8, 0);
    expect_blk("tmo_blk", 64'h4041_4243_4445_4647);
    wait_idle(n);
    chk("tmo_wait", n, 9);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_cnt", blk_count, 7);

    resp_mask = 32'h100;
    burst(8'h50, 8'h01, 8, 0);
    expect_blk("rdywin_blk", 64'h5051_5253_5455_5657);
    wait_idle(n);
    chk("rdywin_wait", n, 9);
    chk("wrap_cnt", blk_count, 0);
    chk("err_sticky", timeout_err, 1);

    resp_mask = 32'h4;
    burst(8'h60, 8'h01, 5, 0);
    do_reset();
    burst(8'h10, 8'h01, 8, 0);
    expect_blk("post_rst", 64'h1011_1213_1415_1617);
    wait_idle(n);
    chk("post_rst_cnt", blk_count, 1);

    burst(8'h70, 8'h01, 8, 0);
    expect_blk("pre_wrst", 64'h7071_7273_7475_7677);
    @(posedge clk);
    do_reset();
    e0 = en_cnt;
    repeat (6) @(negedge clk);
    #1;
    chk("no_stray_en", en_cnt, e0);
    burst(8'h80, 8'h01, 8, 0);
    expect_blk("post_wrst", 64'h8081_8283_8485_8687);
    wait_idle(n);
    chk("post_wrst_cnt", blk_count, 1);
    chk("post_wrst_err", timeout_err, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
